// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : One-hot control sequencer for the Harvard CPU. Latches the
//               instruction word, steps FETCH/EXEC1..3 per opcode, and
//               handles run, single-step, halt request and STP stop.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int IW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          step,
  input  logic          halt_req,
  input  logic          resume,
  input  logic [IW-1:0] instr_in,
  output logic [3:0]    state,
  output logic [3:0]    inst,
  output logic [IW-5:0] operand,
  output logic          busy,
  output logic          halted,
  output logic [CW-1:0] retired
);

  localparam logic [3:0] C_OP_STP = 4'b0010;
  localparam logic [3:0] C_OP_LDA = 4'b0011;
  localparam logic [3:0] C_OP_MUL = 4'b1101;
  localparam logic [3:0] C_OP_LDR = 4'b1110;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0000,
    S_FETCH = 4'b0001,
    S_EXEC1 = 4'b0010,
    S_EXEC2 = 4'b0100,
    S_EXEC3 = 4'b1000
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_single;
  logic          w_single_nxt;
  logic [3:0]    r_inst;
  logic [IW-5:0] r_operand;
  logic          r_halted;
  logic          w_halt_set;
  logic [CW-1:0] r_retired;
  logic          w_len2;
  logic          w_len3;
  logic          w_last;
  logic          w_end_state;

  // Execute length is decided by the latched opcode, never by live memory data.
  always_comb begin
    w_len2 = (r_inst == C_OP_LDA) || (r_inst == C_OP_LDR);
    w_len3 = (r_inst == C_OP_MUL);
    w_last = ((r_state == S_EXEC1) && !w_len2 && !w_len3) ||
             ((r_state == S_EXEC2) && w_len2) ||
             (r_state == S_EXEC3);
  end

  // State and single-step flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_single <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_single <= w_single_nxt;
    end
  end

  // Next-state logic; run and halt_req only matter at instruction boundaries.
  always_comb begin
    w_state_nxt  = r_state;
    w_single_nxt = r_single;
    w_halt_set   = 1'b0;
    w_end_state  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_halted && (run || step)) begin
          w_state_nxt  = S_FETCH;
          w_single_nxt = !run;
        end
      end
      S_FETCH: w_state_nxt = S_EXEC1;
      S_EXEC1: begin
        if (w_last) w_end_state = 1'b1;
        else        w_state_nxt = S_EXEC2;
      end
      S_EXEC2: begin
        if (w_last) w_end_state = 1'b1;
        else        w_state_nxt = S_EXEC3;
      end
      S_EXEC3: w_end_state = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_end_state) begin
      if (r_inst == C_OP_STP) begin
        w_state_nxt = S_IDLE;
        w_halt_set  = 1'b1;
      end else if (r_single || halt_req || !run) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_FETCH;
      end
    end
  end

  // Instruction register loads only on the FETCH->EXEC1 edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst    <= 4'b0000;
      r_operand <= '0;
    end else if (r_state == S_FETCH) begin
      r_inst    <= instr_in[IW-1:IW-4];
      r_operand <= instr_in[IW-5:0];
    end
  end

  // Sticky halt flag: STP completion takes priority over a same-cycle resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_halted <= 1'b0;
    else if (w_halt_set) r_halted <= 1'b1;
    else if (resume)     r_halted <= 1'b0;
  end

  // Retired counter bumps on the edge leaving the last exec state, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_retired <= '0;
    else if (w_last) r_retired <= r_retired + CW'(1);
  end

  assign state   = r_state;
  assign inst    = r_inst;
  assign operand = r_operand;
  assign busy    = (r_state != S_IDLE);
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       halt_req;
  logic       resume;
  logic [7:0] instr_in;
  logic [3:0] state;
  logic [3:0] inst;
  logic [3:0] operand;
  logic       busy;
  logic       halted;
  logic [15:0] retired;
  logic [3:0] state_w;
  logic [3:0] inst_w;
  logic [3:0] operand_w;
  logic       busy_w;
  logic       halted_w;
  logic [3:0] retired_w;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] C_JMP = 8'h1A;
  localparam logic [7:0] C_LDA = 8'h35;
  localparam logic [7:0] C_MUL = 8'hD7;
  localparam logic [7:0] C_LDR = 8'hE9;
  localparam logic [7:0] C_STP = 8'h20;

  always #5 clk = ~clk;

  control_sequencer #(.IW(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .resume(resume), .instr_in(instr_in), .state(state), .inst(inst),
    .operand(operand), .busy(busy), .halted(halted), .retired(retired)
  );

  // Narrow-counter instance sharing all stimulus, used to reach the wrap point.
  control_sequencer #(.IW(8), .CW(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .resume(resume), .instr_in(instr_in), .state(state_w), .inst(inst_w),
    .operand(operand_w), .busy(busy_w), .halted(halted_w), .retired(retired_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; resume = 1'b0;
    instr_in = C_JMP;
    tick(); tick();
    // reset values
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_operand", 32'(operand), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    rst_n = 1'b1;

    // run with JMP, LDA, MUL
    run = 1'b1; instr_in = C_JMP;
    tick(); chk("t1_s0", 32'(state), 32'h1);
    tick(); chk("t1_s1", 32'(state), 32'h2);
    chk("t1_inst_jmp", 32'(inst), 32'h1);
    chk("t1_operand", 32'(operand), 32'hA);
    instr_in = C_LDA;
    tick(); chk("t1_s2", 32'(state), 32'h1);
    chk("t1_ret1", 32'(retired), 32'd1);
    tick(); chk("t1_s3", 32'(state), 32'h2);
    chk("t1_inst_lda", 32'(inst), 32'h3);
    tick(); chk("t1_s4", 32'(state), 32'h4);
    instr_in = C_MUL;
    tick(); chk("t1_s5", 32'(state), 32'h1);
    tick(); chk("t1_s6", 32'(state), 32'h2);
    chk("t1_inst_mul", 32'(inst), 32'hD);
    tick(); chk("t1_s7", 32'(state), 32'h4);
    tick(); chk("t1_s8", 32'(state), 32'h8);
    chk("t1_ret2", 32'(retired), 32'd2);
    instr_in = C_JMP;
    tick(); chk("t1_s9", 32'(state), 32'h1);
    chk("t1_ret3", 32'(retired), 32'd3);
    run = 1'b0;
    tick(); chk("t1_s10", 32'(state), 32'h2);
    tick(); chk("t1_stop", 32'(state), 32'h0);
    chk("t1_ret4", 32'(retired), 32'd4);
    chk("t1_inst_hold", 32'(inst), 32'h1);

    // single step with LDR
    instr_in = C_LDR; step = 1'b1;
    tick(); chk("t2_s0", 32'(state), 32'h1);
    step = 1'b0;
    tick(); chk("t2_s1", 32'(state), 32'h2);
    chk("t2_inst", 32'(inst), 32'hE);
    chk("t2_operand", 32'(operand), 32'h9);
    tick(); chk("t2_s2", 32'(state), 32'h4);
    tick(); chk("t2_s3", 32'(state), 32'h0);
    chk("t2_ret", 32'(retired), 32'd5);
    chk("t2_busy", 32'(busy), 32'h0);
    tick(); chk("t2_busy_hold", 32'(busy), 32'h0);

    // STP while running
    run = 1'b1; instr_in = C_STP;
    tick(); chk("t3_s0", 32'(state), 32'h1);
    tick(); chk("t3_s1", 32'(state), 32'h2);
    chk("t3_inst", 32'(inst), 32'h2);
    tick(); chk("t3_s2", 32'(state), 32'h0);
    chk("t3_halted", 32'(halted), 32'h1);
    chk("t3_ret", 32'(retired), 32'd6);
    step = 1'b1;
    tick(); chk("t3_ign0", 32'(state), 32'h0);
    tick(); chk("t3_ign1", 32'(state), 32'h0);
    step = 1'b0; resume = 1'b1; instr_in = C_MUL;
    tick(); chk("t3_res_state", 32'(state), 32'h0);
    chk("t3_res_halted", 32'(halted), 32'h0);
    resume = 1'b0;
    tick(); chk("t3_refetch", 32'(state), 32'h1);

    // halt_req during MUL EXEC2
    tick(); chk("t4_s1", 32'(state), 32'h2);
    tick(); chk("t4_s2", 32'(state), 32'h4);
    halt_req = 1'b1;
    tick(); chk("t4_exec3", 32'(state), 32'h8);
    chk("t4_ret_mid", 32'(retired), 32'd6);
    tick(); chk("t4_idle", 32'(state), 32'h0);
    chk("t4_ret", 32'(retired), 32'd7);
    halt_req = 1'b0; run = 1'b0;

    // async reset during LDA EXEC2
    run = 1'b1; instr_in = C_LDA;
    tick(); chk("t5_s0", 32'(state), 32'h1);
    tick(); chk("t5_s1", 32'(state), 32'h2);
    tick(); chk("t5_s2", 32'(state), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_state", 32'(state), 32'h0);
    chk("t5_inst", 32'(inst), 32'h0);
    chk("t5_operand", 32'(operand), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_retired", 32'(retired), 32'h0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;

    // counter wrap on the narrow instance
    run = 1'b1; instr_in = C_JMP;
    for (int i = 0; i < 31; i++) tick();
    chk("t6_w_pre", 32'(retired_w), 32'hF);
    chk("t6_state", 32'(state), 32'h1);
    run = 1'b0;
    tick(); tick();
    chk("t6_w_wrap", 32'(retired_w), 32'h0);
    chk("t6_ret16", 32'(retired), 32'd16);
    chk("t6_idle", 32'(state), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

One-hot control sequencer for the Harvard-architecture CPU. It drives the 4-bit `state` vector (fetch/exec1/exec2/exec3) and the 4-bit opcode `inst` that the instruction decoder consumes. It latches each instruction word from program memory and chooses 1, 2 or 3 execute cycles per opcode. It also handles run, single-step, halt request and the STP stop instruction.

## Interface
- `IW`, default 8: instruction word width. Opcode is `instr_in[IW-1:IW-4]`; operand is `instr_in[IW-5:0]`.
- `CW`, default 16: width of the retired-instruction counter.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `run` input 1: level. Continue issuing instructions while high.
- `step` input 1: single-cycle pulse. Execute exactly one instruction from IDLE.
- `halt_req` input 1: level. Stop at the next instruction boundary.
- `resume` input 1: single-cycle pulse. Clears the sticky `halted` flag.
- `instr_in` input IW: program memory read data. Valid during FETCH.
- `state` output 4: one-hot to the decoder. Bit0 FETCH, bit1 EXEC1, bit2 EXEC2, bit3 EXEC3. 0000 in IDLE.
- `inst` output 4: registered opcode (IR) to the decoder.
- `operand` output IW-4: registered operand field.
- `busy` output 1: high in any state other than IDLE.
- `halted` output 1: sticky. Set by executing STP.
- `retired` output CW: count of completed instructions, wraps.

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, EXEC3. Registered and one-hot encoded, with IDLE = 0000.
- IDLE -> FETCH when `~halted & (run | step)`. If `run` is low, a `step` sets internal `single` = 1. Otherwise `single` = 0.
- FETCH -> EXEC1 always. On this edge, IR/`inst` <= opcode and `operand` <= operand field of `instr_in`.
- Execute length is set by the `inst` opcode:
  - LDA 0011 and LDR 1110: EXEC1 -> EXEC2 -> end.
  - MUL 1101: EXEC1 -> EXEC2 -> EXEC3 -> end.
  - All other opcodes: EXEC1 -> end.
- At the end of an instruction (its last exec state), `retired` increments by 1, modulo 2^CW.
- Next state after the last exec state:
  - IDLE if `inst` = STP (0010). `halted` <= 1 on the same edge.
  - Otherwise IDLE if `single` or `halt_req` or `~run`.
  - Otherwise FETCH.
- `halt_req` and `run` are sampled only at instruction boundaries. A running instruction always completes all of its exec cycles.
- `resume` clears `halted` in any state. If `resume` and STP completion occur on the same edge, `halted` ends at 1 (set wins).
- In IDLE, `step` and `run` are ignored while `halted` = 1. A `step` arriving while busy is ignored, not queued.
- Unused opcodes (1000–1100, 1111) take the 1-exec path. The sequencer does not trap them.

## Timing
- Reset (async, `rst_n` low):
  - state = IDLE, `state` = 0000, `inst` = 0000, `operand` = 0.
  - `busy` = 0, `halted` = 0, `retired` = 0, `single` = 0.
  - All outputs take these values immediately on `rst_n` falling, including mid-instruction. No partial instruction is retired.
- All outputs are registered. No combinational path from inputs to outputs.
- `run` or `step` high in IDLE -> `state` = 0001 on the next edge (1-cycle latency).
- Instruction duration in cycles including FETCH: 2 for default opcodes, 3 for LDA/LDR, 4 for MUL.
- Back-to-back instructions: the last exec state is followed directly by FETCH, with no IDLE bubble.
- `inst` changes only on the FETCH->EXEC1 edge. It is stable through all exec states and holds its value in IDLE.
- `retired` updates on the edge that leaves the last exec state.

## Test plan
- Reset, then `run` = 1 with opcode stream JMP(0001), LDA(0011), MUL(1101).
  - `state`: 0001, 0010, 0001, 0010, 0100, 0001, 0010, 0100, 1000, 0001.
  - `retired` = 3 after 9 cycles.
- `run` = 0, `step` pulse with an LDR(1110) word.
  - `state`: 0001, 0010, 0100, 0000.
  - `retired` = 1; `busy` then stays 0.
- STP(0010) issued while running.
  - Sequence is FETCH, EXEC1, then IDLE with `halted` = 1.
  - Further `run` and `step` leave `state` = 0000 until a `resume` pulse. The next edge after that enters FETCH if `run` = 1.
- `halt_req` asserted during MUL EXEC2.
  - EXEC3 still occurs, then IDLE. `retired` increments once.
- `rst_n` pulsed low during EXEC2 of LDA.
  - All outputs are at reset values immediately. `retired` is not incremented.
- Preload `retired` = 0xFFFF by running 65535 JMP instructions (or force), then retire one more: `retired` = 0x0000.
